// File: rtl/half_adder_core_if.sv
// Operand/result bundle for half_adder_core: valid-qualified A/B in, registered difference/borrow out.
interface half_adder_core_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (output in_valid, A, B, input out_valid, diff, borrow);
    modport slave  (input in_valid, A, B, output out_valid, diff, borrow);
endinterface

// File: rtl/half_adder_core.sv
// Pipelined ripple-borrow subtractor (A - B) with valid tracking and a saturating borrow-event counter.
// WIDTH=1 degenerates to a plain half subtractor.
module half_adder_core #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    half_adder_core_if.slave     bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     borrow_cnt
);

    localparam int unsigned RES_W = WIDTH + 1;

    logic [RES_W-1:0] sub_res_c;
    logic             pv [STAGES];
    logic [RES_W-1:0] pd [STAGES];
    logic             last_valid;
    logic             last_borrow;

    // Bit-serial borrow chain; result packs {borrow_out, diff}.
    function automatic logic [RES_W-1:0] sub_ripple(input logic [WIDTH-1:0] mn,
                                                    input logic [WIDTH-1:0] sb);
        logic [WIDTH:0]   bw;
        logic [WIDTH-1:0] d;
        bw = '0;
        d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            d[i]    = mn[i] ^ sb[i] ^ bw[i];
            bw[i+1] = (~mn[i] & sb[i]) | (~(mn[i] ^ sb[i]) & bw[i]);
        end
        return {bw[WIDTH], d};
    endfunction

    always_comb begin
        sub_res_c = sub_ripple(bus.A, bus.B);
    end

    // Result and valid travel together; data registers only load on a valid token so outputs hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(STAGES); j++) begin
                pv[j] <= 1'b0;
                pd[j] <= '0;
            end
        end else begin
            pv[0] <= bus.in_valid;
            if (bus.in_valid) begin
                pd[0] <= sub_res_c;
            end
            for (int j = 1; j < int'(STAGES); j++) begin
                pv[j] <= pv[j-1];
                if (pv[j-1]) begin
                    pd[j] <= pd[j-1];
                end
            end
        end
    end

    assign last_valid    = pv[STAGES-1];
    assign last_borrow   = pd[STAGES-1][WIDTH];
    assign bus.out_valid = last_valid;
    assign bus.diff      = pd[STAGES-1][WIDTH-1:0];
    assign bus.borrow    = last_borrow;

    // Saturating underflow counter; a same-cycle clear wins over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_cnt <= '0;
        end else if (cnt_clr) begin
            borrow_cnt <= '0;
        end else if (last_valid && last_borrow && (borrow_cnt != '1)) begin
            borrow_cnt <= borrow_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_adder_core.sv
// Directed bench for half_adder_core: truth table, wrap-around, pipelining, counter saturation/clear, resets.
module tb_half_adder_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    half_adder_core_if #(.WIDTH(1)) i1 ();
    half_adder_core_if #(.WIDTH(8)) i8 ();
    half_adder_core_if #(.WIDTH(8)) i3 ();
    half_adder_core_if #(.WIDTH(8)) ic ();

    logic        clr1, clr8, clr3, clrc;
    logic [15:0] cnt1, cnt8, cnt3;
    logic [3:0]  cntc;

    half_adder_core #(.WIDTH(1), .STAGES(1), .CNT_W(16)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(i1), .cnt_clr(clr1), .borrow_cnt(cnt1));
    half_adder_core #(.WIDTH(8), .STAGES(1), .CNT_W(16)) d8 (
        .clk(clk), .rst_n(rst_n), .bus(i8), .cnt_clr(clr8), .borrow_cnt(cnt8));
    half_adder_core #(.WIDTH(8), .STAGES(3), .CNT_W(16)) d3 (
        .clk(clk), .rst_n(rst_n), .bus(i3), .cnt_clr(clr3), .borrow_cnt(cnt3));
    half_adder_core #(.WIDTH(8), .STAGES(1), .CNT_W(4)) dc (
        .clk(clk), .rst_n(rst_n), .bus(ic), .cnt_clr(clrc), .borrow_cnt(cntc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pipeline vectors and their hand-computed results.
    logic [7:0] pa [5] = '{8'h10, 8'h03, 8'hFF, 8'h00, 8'h7F};
    logic [7:0] pb [5] = '{8'h03, 8'h10, 8'hFF, 8'h80, 8'h00};
    logic [7:0] pe [5] = '{8'h0D, 8'hF3, 8'h00, 8'h80, 8'h7F};
    logic       pw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        {clr1, clr8, clr3, clrc} = 4'b0;
        i1.in_valid = 1'b0; i1.A = '0; i1.B = '0;
        i8.in_valid = 1'b0; i8.A = '0; i8.B = '0;
        i3.in_valid = 1'b0; i3.A = '0; i3.B = '0;
        ic.in_valid = 1'b0; ic.A = '0; ic.B = '0;

        // Reset held with random stimulus.
        for (int k = 0; k < 4; k++) begin
            i1.in_valid = 1'($urandom_range(0, 1));
            i1.A = 1'($urandom_range(0, 1));
            i1.B = 1'($urandom_range(0, 1));
            i3.in_valid = 1'($urandom_range(0, 1));
            i3.A = 8'($urandom);
            i3.B = 8'($urandom);
            step();
            chk("rst_valid1", 32'(i1.out_valid), 32'd0);
            chk("rst_diff1", 32'(i1.diff), 32'd0);
            chk("rst_borrow1", 32'(i1.borrow), 32'd0);
            chk("rst_cnt1", 32'(cnt1), 32'd0);
            chk("rst_valid3", 32'(i3.out_valid), 32'd0);
            chk("rst_diff3", 32'(i3.diff), 32'd0);
        end
        i1.in_valid = 1'b0;
        i3.in_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rel_valid1", 32'(i1.out_valid), 32'd0);
            chk("rel_valid3", 32'(i3.out_valid), 32'd0);
        end

        // WIDTH=1 truth table, back to back.
        i1.in_valid = 1'b1;
        i1.A = 1'b0; i1.B = 1'b0; step();
        chk("tt00_valid", 32'(i1.out_valid), 32'd1);
        chk("tt00", 32'({i1.diff, i1.borrow}), 32'b00);
        i1.A = 1'b0; i1.B = 1'b1; step();
        chk("tt01_valid", 32'(i1.out_valid), 32'd1);
        chk("tt01", 32'({i1.diff, i1.borrow}), 32'b11);
        i1.A = 1'b1; i1.B = 1'b0; step();
        chk("tt10", 32'({i1.diff, i1.borrow}), 32'b10);
        i1.A = 1'b1; i1.B = 1'b1; step();
        chk("tt11", 32'({i1.diff, i1.borrow}), 32'b00);
        chk("tt_cnt", 32'(cnt1), 32'd1);
        i1.in_valid = 1'b0; i1.A = 1'b0; i1.B = 1'b1;
        step();
        chk("tt_idle_valid", 32'(i1.out_valid), 32'd0);
        chk("tt_idle_hold", 32'({i1.diff, i1.borrow}), 32'b00);
        chk("tt_idle_cnt", 32'(cnt1), 32'd1);

        // WIDTH=8 wrap-around.
        i8.in_valid = 1'b1;
        i8.A = 8'h00; i8.B = 8'h01; step();
        chk("wrap_00_01", 32'({i8.borrow, i8.diff}), 32'h1FF);
        i8.A = 8'h80; i8.B = 8'h7F; step();
        chk("wrap_80_7f", 32'({i8.borrow, i8.diff}), 32'h001);
        i8.A = 8'hA5; i8.B = 8'hA5; step();
        chk("wrap_a5_a5", 32'({i8.borrow, i8.diff}), 32'h000);
        chk("wrap_valid", 32'(i8.out_valid), 32'd1);
        i8.in_valid = 1'b0;
        step();
        chk("wrap_idle", 32'(i8.out_valid), 32'd0);
        chk("wrap_cnt", 32'(cnt8), 32'd1);

        // STAGES=3: five back-to-back tokens then a gap.
        for (int s = 0; s < 9; s++) begin
            if (s < 5) begin
                i3.in_valid = 1'b1; i3.A = pa[s]; i3.B = pb[s];
            end else begin
                i3.in_valid = 1'b0; i3.A = 8'h55; i3.B = 8'hAA;
            end
            step();
            chk($sformatf("pipe_valid%0d", s), 32'(i3.out_valid), 32'((s >= 2) && (s <= 6)));
            if (s >= 2 && s <= 6) begin
                chk($sformatf("pipe_res%0d", s), 32'({i3.borrow, i3.diff}), 32'({pw[s-2], pe[s-2]}));
            end else if (s > 6) begin
                chk($sformatf("pipe_hold%0d", s), 32'({i3.borrow, i3.diff}), 32'h07F);
            end
        end
        chk("pipe_cnt", 32'(cnt3), 32'd2);

        // CNT_W=4 saturation.
        ic.in_valid = 1'b1; ic.A = 8'h00; ic.B = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) chk("sat_mid", 32'(cntc), 32'd9);
        end
        ic.in_valid = 1'b0;
        step();
        step();
        chk("sat_cnt", 32'(cntc), 32'd15);

        // Clear, then clear colliding with a borrowing result.
        clrc = 1'b1; step();
        chk("clr_plain", 32'(cntc), 32'd0);
        clrc = 1'b0;
        ic.in_valid = 1'b1; step();
        ic.in_valid = 1'b0; step();
        chk("clr_recount", 32'(cntc), 32'd1);
        ic.in_valid = 1'b1; step();
        chk("clr_ev_valid", 32'({ic.out_valid, ic.borrow}), 32'b11);
        clrc = 1'b1; ic.in_valid = 1'b0; step();
        chk("clr_wins", 32'(cntc), 32'd0);
        clrc = 1'b0; step();
        chk("clr_after", 32'(cntc), 32'd0);

        // Mid-operation reset with two tokens in flight.
        i3.in_valid = 1'b1; i3.A = 8'h00; i3.B = 8'h01; step();
        i3.A = 8'h05; i3.B = 8'h09; step();
        i3.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_diff", 32'(i3.diff), 32'd0);
        chk("mid_async_cnt", 32'(cnt3), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_valid", 32'(i3.out_valid), 32'd0);
            chk("mid_out", 32'({i3.borrow, i3.diff}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_adder_core.md
# half_adder_core

Registered one-bit half-subtractor datapath with a valid qualifier and a borrow-event counter, generalised by a width parameter into a ripple-borrow subtractor. Despite the block name it subtracts: it computes A − B, producing a difference and a borrow-out. It sits in the arithmetic datapath and feeds downstream logic that needs a clocked difference/borrow pair plus a running count of underflow events.

## Interface

Reset is asynchronous and active-low. The block has one clock.

Parameters:
- `WIDTH`, default 1: operand width in bits. Legal range is 1–32. With WIDTH=1 the block is a pure half subtractor.
- `STAGES`, default 1: number of register stages from input to output. Legal range is 1–4.
- `CNT_W`, default 16: width of the borrow-event counter.

Ports:
- `clk`  input  1: the single clock; all registers update on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: operands A and B are valid this cycle.
- `A`  input  WIDTH: minuend.
- `B`  input  WIDTH: subtrahend.
- `cnt_clr`  input  1: synchronous clear of the borrow counter.
- `out_valid`  output  1: diff and borrow hold a new result this cycle.
- `diff`  output  WIDTH: (A − B) mod 2^WIDTH.
- `borrow`  output  1: 1 when A < B, treating both as unsigned.
- `borrow_cnt`  output  CNT_W: saturating count of valid results that had borrow = 1.

## Operation

- Bit cell i is a half subtractor extended with a borrow-in:
  - d_i = A_i ^ B_i ^ b_i
  - b_{i+1} = (~A_i & B_i) | (~(A_i ^ B_i) & b_i)
  - b_0 = 0.
- `borrow` = b_WIDTH.
- For WIDTH=1 this reduces to diff = A ^ B and borrow = ~A & B.
- Arithmetic is unsigned. `diff` wraps modulo 2^WIDTH. There is no signed overflow flag.
- The result is computed combinationally from A and B, then carried through STAGES registers together with in_valid.
- `diff` and `borrow` update only when a valid token reaches the output stage. Otherwise they hold their last value.
- `out_valid` is high for exactly one cycle per accepted input. There is no backpressure: every cycle with in_valid=1 is accepted.
- Borrow counter:
  - It increments when out_valid=1 and borrow=1.
  - It saturates at 2^CNT_W − 1 and does not wrap.
  - `cnt_clr`=1 forces it to 0 on the next edge. Clear takes precedence over a same-cycle increment, so that event is not counted.
- A and B are ignored when in_valid=0.

## Timing

- Reset (rst_n=0, asynchronous assertion) immediately forces:
  - out_valid = 0, diff = 0, borrow = 0, borrow_cnt = 0
  - all pipeline valid bits = 0.
- Reset release is sampled synchronously. The first edge with rst_n=1 may already accept an input.
- Latency: an input valid at edge k appears on the outputs after edge k+STAGES−1+1. With STAGES=1 the result is visible one cycle after the input.
- Throughput is one result per cycle. Back-to-back inputs produce back-to-back out_valid pulses in input order.
- If reset asserts mid-operation, all in-flight tokens are discarded and no out_valid follows.
- borrow_cnt reflects an increment one cycle after the corresponding out_valid.

## Test plan

- **Reset:** hold rst_n=0 with random A/B/in_valid → out_valid=0, diff=0, borrow=0, borrow_cnt=0 throughout. Release reset → no spurious out_valid.
- **Truth table (WIDTH=1, STAGES=1):** apply (A,B) = (0,0), (0,1), (1,0), (1,1) with in_valid=1 on consecutive cycles → (diff,borrow) one cycle later = (0,0), (1,1), (1,0), (0,0). After the last result, borrow_cnt=1.
- **Wrap-around (WIDTH=8):**
  - A=0x00, B=0x01 → diff=0xFF, borrow=1
  - A=0x80, B=0x7F → diff=0x01, borrow=0
  - A=B=0xA5 → diff=0x00, borrow=0.
- **Pipeline (STAGES=3):** 5 back-to-back valid inputs, then a gap → 5 consecutive out_valid pulses starting 3 cycles after the first input, results in order. diff and borrow hold during the gap.
- **Counter:**
  - CNT_W=4, 20 borrowing inputs → borrow_cnt saturates at 15.
  - Assert cnt_clr in the same cycle as a borrowing out_valid → borrow_cnt=0 next cycle.
- **Mid-operation reset:** STAGES=3, pulse rst_n low while 2 tokens are in flight → no out_valid afterwards, all outputs 0.
